// File: rtl/data_cache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines.
// Word accesses from the pipeline are served from the arrays or turned into 256-bit line transfers.
module data_cache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_mbe,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 32 - 5 - S_INDEX;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [26:0]        miss_line_q, miss_line_d;

    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [255:0]       data_q [SETS];

    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;
    logic [7:0]         word_base;
    logic               req_valid;
    logic               hit;
    logic [255:0]       hit_line;
    logic [31:0]        merged_word;

    logic               line_we;
    logic [S_INDEX-1:0] line_index;
    logic [255:0]       line_data;
    logic               tag_we;

    logic               unused_addr_bits;

    assign req_index        = mem_address[4+S_INDEX:5];
    assign req_tag          = mem_address[31:5+S_INDEX];
    assign word_base        = {mem_address[4:2], 5'b00000};
    assign miss_index       = miss_line_q[S_INDEX-1:0];
    assign miss_tag         = miss_line_q[26:S_INDEX];
    assign req_valid        = mem_read | mem_write;
    assign hit_line         = data_q[req_index];
    assign hit              = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign unused_addr_bits = ^mem_address[1:0];

    // Byte-enable merge of the write data into the currently stored word.
    always_comb begin
        merged_word = hit_line[word_base +: 32];
        for (int b = 0; b < 4; b++) begin
            if (mem_mbe[b]) begin
                merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        miss_line_d  = miss_line_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_we      = 1'b0;
        line_index   = req_index;
        line_data    = hit_line;
        tag_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (mem_read) begin
                            mem_rdata = hit_line[word_base +: 32];
                        end else if (mem_mbe != 4'b0000) begin
                            line_we                       = 1'b1;
                            line_data[word_base +: 32]    = merged_word;
                            dirty_d[req_index]            = 1'b1;
                        end
                    end else begin
                        // The miss line is latched so the transfer stays stable if the CPU lets go.
                        miss_line_d = mem_address[31:5];
                        if (valid_q[req_index] && dirty_q[req_index]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_index], miss_index, 5'b00000};
                pmem_wdata   = data_q[miss_index];
                if (pmem_resp) begin
                    dirty_d[miss_index] = 1'b0;
                    state_d             = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_index, 5'b00000};
                if (pmem_resp) begin
                    line_we             = 1'b1;
                    line_index          = miss_index;
                    line_data           = pmem_rdata;
                    tag_we              = 1'b1;
                    valid_d[miss_index] = 1'b1;
                    dirty_d[miss_index] = 1'b0;
                    state_d             = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_line_q <= miss_line_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[line_index] <= line_data;
        end
        if (tag_we) begin
            tag_q[miss_index] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Bench for data_cache_responder: directed scenarios then random traffic, checked against
// a flat CPU-visible memory model, a backing-memory model and a per-set residency directory.
module tb_data_cache_responder;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_mbe;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    logic [31:0]  ref_mem [logic [29:0]];
    logic [255:0] backing [logic [26:0]];
    bit           dir_valid [8];
    logic [26:0]  dir_line  [8];
    bit           dir_dirty [8];

    data_cache_responder #(.S_INDEX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_mbe      (mem_mbe),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_read({la, 3'(w)});
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        logic [255:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, 3'(w)});
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access: holds the request, plays the memory side with random latency,
    // and checks latency, transfer ordering/addresses/data and returned read data.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [3:0] mbe, input logic [31:0] wd,
                                 output logic [31:0] rdata);
        logic [2:0]  set;
        logic [26:0] line;
        logic [31:0] w;
        bit hit_exp, wb_exp, saw_wb, saw_fill, done;
        int cyc, fill_cyc;
        set      = addr[7:5];
        line     = addr[31:5];
        hit_exp  = dir_valid[set] && (dir_line[set] == line);
        wb_exp   = !hit_exp && dir_valid[set] && dir_dirty[set];
        saw_wb   = 1'b0;
        saw_fill = 1'b0;
        done     = 1'b0;
        cyc      = 0;
        fill_cyc = -10;
        rdata    = '0;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_mbe     = mbe;
        mem_wdata   = wd;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                checkOutput("resp_timing", cyc == (hit_exp ? 1 : fill_cyc + 1), 1'b1);
                if (rd) begin
                    rdata = mem_rdata;
                    checkOutput("read_data", mem_rdata, ref_read(addr[31:2]));
                end else if (wr) begin
                    w = ref_read(addr[31:2]);
                    for (int b = 0; b < 4; b++) if (mbe[b]) w[8*b +: 8] = wd[8*b +: 8];
                    ref_mem[addr[31:2]] = w;
                end
                if (!hit_exp) begin
                    dir_valid[set] = 1'b1;
                    dir_line[set]  = line;
                    dir_dirty[set] = 1'b0;
                end
                if (!rd && wr && mbe != 4'b0000) dir_dirty[set] = 1'b1;
                done = 1'b1;
                @(posedge clk);
                #1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end else if (pmem_write) begin
                if (!saw_wb) begin
                    checkOutput("wb_expected", wb_exp && !saw_fill, 1'b1);
                    checkOutput("wb_addr", pmem_address, {dir_line[set], 5'b00000});
                    checkOutput("wb_data", pmem_wdata, ref_line(dir_line[set]));
                    checkOutput("wb_excl", pmem_read, 1'b0);
                    saw_wb = 1'b1;
                end
                if ($urandom_range(0, 2) == 0) begin
                    backing[dir_line[set]] = pmem_wdata;
                    dir_dirty[set] = 1'b0;
                    pmem_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    pmem_resp = 1'b0;
                end
            end else if (pmem_read) begin
                if (!saw_fill) begin
                    checkOutput("fill_expected", !hit_exp && (saw_wb == wb_exp), 1'b1);
                    checkOutput("fill_addr", pmem_address, {line, 5'b00000});
                    checkOutput("fill_excl", pmem_write, 1'b0);
                    saw_fill = 1'b1;
                end
                if ($urandom_range(0, 2) == 0) begin
                    pmem_rdata = mem_line(line);
                    pmem_resp  = 1'b1;
                    fill_cyc   = cyc;
                    @(posedge clk);
                    #1;
                    pmem_resp = 1'b0;
                end
            end
        end
        checkOutput("completed", done, 1'b1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0]  rdata;
        logic [255:0] l;
        logic [31:0]  addr;
        bit           seen;
        int           op;

        rst         = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_mbe     = 4'b0000;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        for (int s = 0; s < 8; s++) begin
            dir_valid[s] = 1'b0;
            dir_line[s]  = '0;
            dir_dirty[s] = 1'b0;
        end

        // Line 0x100 gets known contents in words 1 and 2.
        l = mem_line(27'h8);
        l[1*32 +: 32] = 32'hDEAD_BEEF;
        l[2*32 +: 32] = 32'hCAFE_F00D;
        backing[27'h8] = l;
        ref_mem[30'h41] = 32'hDEAD_BEEF;
        ref_mem[30'h42] = 32'hCAFE_F00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_resp", mem_resp, 1'b0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
        checkOutput("rst_pmem_read", pmem_read, 1'b0);
        checkOutput("rst_pmem_write", pmem_write, 1'b0);
        checkOutput("rst_pmem_address", pmem_address, 32'h0);
        checkOutput("rst_pmem_wdata", pmem_wdata, 256'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] cold read, hit read, partial write");
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0, rdata);
        checkOutput("cold_read_word1", rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h0000_0108, 4'b0000, 32'h0, rdata);
        checkOutput("hit_read_word2", rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 4'b0110, 32'h1122_3344, rdata);
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0, rdata);
        checkOutput("merged_word", rdata, 32'hDE22_33EF);

        $display("[TB] dirty conflict, then mbe=0 write and clean conflict");
        applyStimulus(1'b1, 1'b0, 32'h0000_1104, 4'b0000, 32'h0, rdata);
        applyStimulus(1'b0, 1'b1, 32'h0000_1104, 4'b0000, 32'hFFFF_FFFF, rdata);
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0, rdata);
        checkOutput("written_back_word", rdata, 32'hDE22_33EF);

        $display("[TB] reset during allocate");
        mem_read    = 1'b1;
        mem_address = 32'h0000_2004;
        seen        = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        checkOutput("alloc_seen", seen, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async_pmem_read", pmem_read, 1'b0);
        checkOutput("async_pmem_write", pmem_write, 1'b0);
        checkOutput("async_pmem_address", pmem_address, 32'h0);
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 8; s++) dir_valid[s] = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0000_2004, 4'b0000, 32'h0, rdata);

        $display("[TB] random traffic");
        for (int n = 0; n < 250; n++) begin
            addr = ($urandom & 32'h0000_03FF) | ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0);
            op   = $urandom_range(0, 9);
            if (op < 4)
                applyStimulus(1'b1, 1'b0, addr, 4'($urandom), 32'($urandom), rdata);
            else if (op < 9)
                applyStimulus(1'b0, 1'b1, addr, 4'($urandom), 32'($urandom), rdata);
            else
                applyStimulus(1'b1, 1'b1, addr, 4'($urandom), 32'($urandom), rdata);
            if ($urandom_range(0, 9) == 0) begin
                pmem_rdata = {8{32'($urandom)}};
                pmem_resp  = 1'b1;
                @(posedge clk);
                #1;
                pmem_resp = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache_responder.md
Name: data_cache_responder

Overview:
Direct-mapped, write-back, write-allocate data cache that answers the pipeline's D-cache port (the data_read/data_write/data_mbe/data_addr/data_wdata, data_resp/data_rdata handshake). It converts word accesses into 256-bit line transfers on a physical-memory port behind it. It sits between the CPU datapath and the memory arbiter/physical memory.

Parameters:
S_INDEX, 3, log2 of set count (8 sets); line is fixed at 32 bytes (offset bits [4:0]), tag is address[31:5+S_INDEX]

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous, active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_mbe  in  4  byte enables for writes, bit i covers mem_wdata[8i+7:8i]
mem_address  in  32  word address; bits [1:0] ignored
mem_wdata  in  32  write data, already byte-lane aligned
mem_resp  out  1  one-cycle completion pulse
mem_rdata  out  32  read word, valid while mem_resp=1
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_address  out  32  line address, bits [4:0]=0
pmem_wdata  out  256  victim line data
pmem_rdata  in  256  fill line data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE; all valid and dirty bits=0; mem_resp, pmem_read, pmem_write=0; mem_rdata, pmem_address, pmem_wdata=0. Tag/data arrays need not be cleared.
- Index=mem_address[4+S_INDEX:5]; word select=mem_address[4:2]; hit = valid[index] && tag[index]==address tag.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: all outputs low.
- IDLE, request and hit: mem_resp=1 combinationally in the same cycle, so latency is 0 extra cycles.
  - Read hit: mem_rdata = line word[word select].
  - Write hit: at the clock edge, bytes with mem_mbe[i]=1 are written into the selected word. dirty[index]=1 only if mem_mbe!=0. mem_mbe=0 completes with no state change.
- IDLE, request and miss: mem_resp=0. If valid&&dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_address={stored tag,index,5'b0}, pmem_wdata=stored line, all stable. On pmem_resp, clear dirty[index] and go to ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={request tag,index,5'b0}. On pmem_resp, load pmem_rdata into the line, write the tag, set valid=1, dirty=0, and return to IDLE. The retry then hits: mem_resp arrives one cycle after pmem_resp. A write miss merges its data on that hit cycle and sets dirty.
- pmem_read and pmem_write are never asserted together. pmem_resp arriving in IDLE is ignored.
- mem_read and mem_write both high is illegal; read takes priority and no write occurs.
- The CPU must hold its request stable until mem_resp. If the request drops mid-miss, the in-flight transfer still completes and the state returns to IDLE with no mem_resp.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: pmem_read and pmem_write fall immediately (async). A line partly loaded when reset hit is invalid after reset.
- mem_resp is never asserted for two consecutive cycles on one request. A new request sampled in the cycle after mem_resp is a new access.

Test Plan:
- Cold read of 0x0000_0104 after reset: no mem_resp, pmem_read=1 with pmem_address=0x0000_0100. Return pmem_rdata with word1=0xDEADBEEF and pmem_resp. Next cycle mem_resp=1, mem_rdata=0xDEADBEEF.
- Read 0x0000_0108 right after that fill: mem_resp in the same cycle, no pmem activity, returns word2 of the filled line.
- Write 0x0000_0104, mbe=4'b0110, wdata=0x11223344, then read 0x0000_0104: returns 0xDE2233EF and the line is dirty.
- Conflict read 0x0000_1104, same index, different tag: pmem_write=1 first, with address 0x0000_0100 and the modified line on pmem_wdata. After pmem_resp, pmem_read=1 at address 0x0000_1100, then mem_resp.
- Write with mbe=0 to a clean hit line, then a conflict miss on the same index: no writeback (pmem_write stays 0), direct ALLOCATE.
- Drive rst low while pmem_read=1 in ALLOCATE: pmem_read drops the same cycle. After release, a read of the same address misses again, so pmem_read is reasserted.
